// File: rtl/sim_mem_pkg.sv
// Shared constants for the latency-accurate simulated memory: command codes, FSM states and the
// LFSR used for randomised latency.
package sim_mem_pkg;

  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 mapped to state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous active-low reset to a fixed seed.
module lfsr16
  import sim_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] state
);

  logic [15:0] state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LFSR_SEED;
    end else if (enable) begin
      state_q <= {state_q[14:0], lfsr_feedback(state_q)};
    end
  end

  assign state = state_q;

endmodule

// File: rtl/sim_mem_lat.sv
// Parametrised simulated word memory with fixed (or, with SIM_MEM_RAND_LAT_EN defined, LFSR
// randomised) response latency, byte-masked writes and an out-of-range error flag.
module sim_mem_lat
  import sim_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W/8-1:0] mem_mask,
  input  logic                mem_enable,
  input  logic                mem_cmd,
  input  logic [DATA_W-1:0]   mem_write_data,
  output logic                mem_ready,
  output logic [DATA_W-1:0]   mem_load_data,
  output logic                mem_valid,
  output logic                mem_error
);

  localparam int unsigned NumBytes  = DATA_W / 8;
  localparam int unsigned ByteShift = (NumBytes > 1) ? $clog2(NumBytes) : 0;
  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW      = $clog2(LATENCY + 1);

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NumBytes-1:0] mask_q;
  logic                cmd_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                valid_q;
  logic                error_q;
  logic [DATA_W-1:0]   load_q;

  logic [DATA_W-1:0]   mem_q [DEPTH_WORDS] = '{default: '0};

  logic                accept;
  logic                resp_entry;
  logic [ADDR_W-1:0]   req_addr;
  logic [NumBytes-1:0] req_mask;
  logic                req_cmd;
  logic [DATA_W-1:0]   req_wdata;
  logic [ADDR_W-1:0]   word_idx;
  logic [IdxW-1:0]     mem_idx;
  logic                in_range;
  logic [CntW-1:0]     req_lat;

`ifdef SIM_MEM_RAND_LAT_EN
  logic [15:0] lfsr_state;

  lfsr16 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .state  (lfsr_state)
  );

  assign req_lat = CntW'(lfsr_state % 16'(LATENCY)) + CntW'(1);
`else
  assign req_lat = CntW'(LATENCY);
`endif

  assign mem_ready = reset && (state_q == StIdle);
  assign accept    = mem_enable && mem_ready;

  // With LATENCY==1 the response edge is the accept edge, so the live inputs are used directly.
  always_comb begin
    req_addr  = addr_q;
    req_mask  = mask_q;
    req_cmd   = cmd_q;
    req_wdata = wdata_q;
    if (state_q == StIdle) begin
      req_addr  = mem_addr;
      req_mask  = mem_mask;
      req_cmd   = mem_cmd;
      req_wdata = mem_write_data;
    end
  end

  assign word_idx = req_addr >> ByteShift;
  assign in_range = word_idx < ADDR_W'(DEPTH_WORDS);
  assign mem_idx  = word_idx[IdxW-1:0];

  assign resp_entry = reset &&
                      ((accept && (req_lat == CntW'(1))) ||
                       ((state_q == StWait) && (cnt_q == CntW'(1))));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      load_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q  <= mem_addr;
            mask_q  <= mem_mask;
            cmd_q   <= mem_cmd;
            wdata_q <= mem_write_data;
            if (req_lat == CntW'(1)) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= req_lat - CntW'(1);
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (resp_entry) begin
        valid_q <= 1'b1;
        error_q <= !in_range;
        if (req_cmd == MEM_CMD_READ) begin
          load_q <= in_range ? mem_q[mem_idx] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resp_entry && (req_cmd == MEM_CMD_WRITE) && in_range) begin
      for (int b = 0; b < int'(NumBytes); b++) begin
        if (req_mask[b]) begin
          mem_q[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign mem_valid     = valid_q;
  assign mem_error     = error_q;
  assign mem_load_data = load_q;

endmodule

// File: tb/tb_sim_mem_lat.sv
// Self-checking bench for sim_mem_lat: directed scenarios plus randomised traffic against a
// word-array reference model.
module tb_sim_mem_lat;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_mask;
  logic          mem_enable;
  logic          mem_cmd;
  logic [DW-1:0] mem_write_data;
  logic          mem_ready;
  logic [DW-1:0] mem_load_data;
  logic          mem_valid;
  logic          mem_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_load;

  sim_mem_lat #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_mask       (mem_mask),
    .mem_enable     (mem_enable),
    .mem_cmd        (mem_cmd),
    .mem_write_data (mem_write_data),
    .mem_ready      (mem_ready),
    .mem_load_data  (mem_load_data),
    .mem_valid      (mem_valid),
    .mem_error      (mem_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte-addressed word array; load data is held across writes.
  task automatic model_op(input logic cmd, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wd, output logic exp_err, output logic [31:0] exp_rd);
    int unsigned idx;
    idx = addr / 4;
    exp_err = (idx >= DEPTH);
    if (cmd && !exp_err) begin
      for (int b = 0; b < 4; b++) if (mask[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end else if (!cmd) begin
      last_load = exp_err ? 32'h0 : model_mem[idx];
    end
    exp_rd = last_load;
  endtask

  // Drives one request and observes the response; lat is cycles from the request cycle to valid.
  task automatic transact(input logic cmd, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wd, input bit junk, output int lat,
                          output logic err, output logic [31:0] rd, output logic single);
    int n;
    n = 0;
    while (!mem_ready && n < 50) begin
      step();
      n++;
    end
    mem_enable = 1'b1;
    mem_cmd = cmd;
    mem_addr = addr;
    mem_mask = mask;
    mem_write_data = wd;
    step();
    lat = -1;
    err = 1'bx;
    rd = 'x;
    single = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (junk) begin
        mem_enable = 1'b1;
        mem_cmd = ~cmd;
        mem_addr = addr ^ 32'h40;
        mem_mask = 4'hF;
        mem_write_data = ~wd;
      end else begin
        mem_enable = 1'b0;
        mem_cmd = 1'($urandom);
        mem_addr = $urandom;
        mem_mask = 4'($urandom);
        mem_write_data = $urandom;
      end
      if (mem_valid) begin
        mem_enable = 1'b0;
        lat = k + 1;
        err = mem_error;
        rd = mem_load_data;
        step();
        single = !mem_valid;
        break;
      end
      step();
    end
    mem_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_enable = 1'b1;
    mem_cmd = 1'b1;
    mem_addr = 32'h10;
    mem_mask = 4'hF;
    mem_write_data = 32'hFFFF_FFFF;
    step();
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (mem_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ready cycle %0d: got %b want 0", c, mem_ready);
      end
      n_cmp++;
      if (mem_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_valid cycle %0d: got %b want 0", c, mem_valid);
      end
      n_cmp++;
      if (mem_load_data !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_load cycle %0d: got %h want 0", c, mem_load_data);
      end
      if (c < 2) step();
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_enable = 1'b0;
    #1;
    n_cmp++;
    if (mem_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 1", mem_ready);
    end
    last_load = 32'h0;
    step();
  endtask

  task automatic test_write_read();
    int lat;
    logic err, single, e_err;
    logic [31:0] rd, e_rd;
    model_op(1'b1, 32'h14, 4'hF, 32'h0000_FFFF, e_err, e_rd);
    transact(1'b1, 32'h14, 4'hF, 32'h0000_FFFF, 1'b0, lat, err, rd, single);
    n_cmp++;
    if (lat !== int'(LAT) || single !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_latency: got %0d single=%b want %0d single=1", lat, single, LAT);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_error: got %b want 0", err);
    end
    model_op(1'b0, 32'h14, 4'h0, 32'h0, e_err, e_rd);
    transact(1'b0, 32'h14, 4'h0, 32'h0, 1'b0, lat, err, rd, single);
    n_cmp++;
    if (lat !== int'(LAT) || single !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_latency: got %0d single=%b want %0d single=1", lat, single, LAT);
    end
    n_cmp++;
    if (rd !== 32'h0000_FFFF || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_data: got %h err=%b want 0000ffff err=0", rd, err);
    end
  endtask

  task automatic test_mask();
    int lat;
    logic err, single, e_err;
    logic [31:0] rd, e_rd;
    model_op(1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF, e_err, e_rd);
    transact(1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF, 1'b0, lat, err, rd, single);
    model_op(1'b1, 32'h20, 4'b0011, 32'h1122_3344, e_err, e_rd);
    transact(1'b1, 32'h20, 4'b0011, 32'h1122_3344, 1'b0, lat, err, rd, single);
    n_cmp++;
    if (rd !== e_rd) begin
      n_bad++;
      $display("FAIL mask_write_holds_load: got %h want %h", rd, e_rd);
    end
    model_op(1'b0, 32'h22, 4'h0, 32'h0, e_err, e_rd);
    transact(1'b0, 32'h22, 4'h0, 32'h0, 1'b0, lat, err, rd, single);
    n_cmp++;
    if (rd !== 32'hDEAD_3344) begin
      n_bad++;
      $display("FAIL mask_read: got %h want dead3344", rd);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic err, single, e_err;
    logic [31:0] rd, e_rd;
    model_op(1'b1, 32'h0, 4'hF, 32'hA5A5_5A5A, e_err, e_rd);
    transact(1'b1, 32'h0, 4'hF, 32'hA5A5_5A5A, 1'b0, lat, err, rd, single);
    model_op(1'b0, 4 * DEPTH, 4'h0, 32'h0, e_err, e_rd);
    transact(1'b0, 4 * DEPTH, 4'h0, 32'h0, 1'b0, lat, err, rd, single);
    n_cmp++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== int'(LAT)) begin
      n_bad++;
      $display("FAIL oor_read: got err=%b rd=%h lat=%0d want err=1 rd=0 lat=%0d",
               err, rd, lat, LAT);
    end
    model_op(1'b1, 4 * DEPTH, 4'hF, 32'h1234_5678, e_err, e_rd);
    transact(1'b1, 4 * DEPTH, 4'hF, 32'h1234_5678, 1'b0, lat, err, rd, single);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_write_error: got %b want 1", err);
    end
    model_op(1'b0, 32'h0, 4'h0, 32'h0, e_err, e_rd);
    transact(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, lat, err, rd, single);
    n_cmp++;
    if (rd !== e_rd || err !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_word0_intact: got %h err=%b want %h err=0", rd, err, e_rd);
    end
  endtask

  task automatic test_ignore_during_wait();
    int lat;
    logic err, single, e_err;
    logic [31:0] rd, e_rd;
    model_op(1'b1, 32'h44, 4'hF, 32'h0BAD_F00D, e_err, e_rd);
    transact(1'b1, 32'h44, 4'hF, 32'h0BAD_F00D, 1'b0, lat, err, rd, single);
    model_op(1'b0, 32'h44, 4'h0, 32'h0BAD_F00D, e_err, e_rd);
    transact(1'b0, 32'h44, 4'h0, 32'h0BAD_F00D, 1'b1, lat, err, rd, single);
    n_cmp++;
    if (rd !== e_rd || lat !== int'(LAT) || single !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_ignore: got rd=%h lat=%0d single=%b want rd=%h lat=%0d single=1",
               rd, lat, single, e_rd, LAT);
    end
    // The ignored request was a write to 0x04; that word must be untouched.
    model_op(1'b0, 32'h04, 4'h0, 32'h0, e_err, e_rd);
    transact(1'b0, 32'h04, 4'h0, 32'h0, 1'b0, lat, err, rd, single);
    n_cmp++;
    if (rd !== e_rd) begin
      n_bad++;
      $display("FAIL busy_no_side_write: got %h want %h", rd, e_rd);
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    logic err, single, e_err;
    logic [31:0] rd, e_rd;
    model_op(1'b1, 32'h30, 4'hF, 32'hCAFE_0030, e_err, e_rd);
    transact(1'b1, 32'h30, 4'hF, 32'hCAFE_0030, 1'b0, lat, err, rd, single);
    mem_enable = 1'b1;
    mem_cmd = 1'b1;
    mem_addr = 32'h30;
    mem_mask = 4'hF;
    mem_write_data = 32'h5555_AAAA;
    step();
    mem_enable = 1'b0;
    step();
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      if (mem_valid) pulses++;
    end
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (mem_valid) pulses++;
      step();
    end
    last_load = 32'h0;
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_valid: got %0d pulses want 0", pulses);
    end
    model_op(1'b0, 32'h30, 4'h0, 32'h0, e_err, e_rd);
    transact(1'b0, 32'h30, 4'h0, 32'h0, 1'b0, lat, err, rd, single);
    n_cmp++;
    if (rd !== e_rd) begin
      n_bad++;
      $display("FAIL reset_mid_contents: got %h want %h", rd, e_rd);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, n;
    logic [31:0] where, e_rd;
    logic e_err;
    n = 0;
    while (!mem_ready && n < 50) begin
      step();
      n++;
    end
    mem_enable = 1'b1;
    mem_cmd = 1'b0;
    mem_addr = 32'h14;
    mem_mask = 4'h0;
    mem_write_data = 32'h0;
    step();
    pulses = 0;
    where = 32'h0;
    for (int k = 0; k < 14; k++) begin
      if (mem_valid) begin
        pulses++;
        where[k] = 1'b1;
      end
      if (k == 13) mem_enable = 1'b0;
      step();
    end
    for (int i = 0; i < 3; i++) model_op(1'b0, 32'h14, 4'h0, 32'h0, e_err, e_rd);
    n_cmp++;
    // Accepts every LAT+1 cycles; responses at sample offsets LAT-1, 2*LAT, 3*LAT+1.
    if (pulses !== 3 || where !== ((32'h1 << (LAT - 1)) | (32'h1 << (2 * LAT)) |
                                   (32'h1 << (3 * LAT + 1)))) begin
      n_bad++;
      $display("FAIL back_to_back: got pulses=%0d at %h", pulses, where);
    end
    n_cmp++;
    if (mem_load_data !== e_rd) begin
      n_bad++;
      $display("FAIL back_to_back_data: got %h want %h", mem_load_data, e_rd);
    end
  endtask

  task automatic test_random();
    int lat;
    logic err, single, e_err, cmd;
    logic [31:0] rd, e_rd, addr, wd;
    logic [3:0] mask;
    for (int i = 0; i < 60; i++) begin
      cmd = 1'($urandom);
      if ($urandom_range(0, 5) == 0) addr = $urandom_range(32'hFFFF_FFFF, 4 * DEPTH);
      else addr = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
      mask = 4'($urandom);
      wd = $urandom;
      model_op(cmd, addr, mask, wd, e_err, e_rd);
      transact(cmd, addr, mask, wd, 1'b0, lat, err, rd, single);
      n_cmp++;
      if (lat !== int'(LAT) || single !== 1'b1 || err !== e_err || rd !== e_rd) begin
        n_bad++;
        $display("FAIL random[%0d] cmd=%b addr=%h: got lat=%0d single=%b err=%b rd=%h want lat=%0d single=1 err=%b rd=%h",
                 i, cmd, addr, lat, single, err, rd, LAT, e_err, e_rd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
    last_load = 32'h0;
    test_reset();
    test_write_read();
    test_mask();
    test_out_of_range();
    test_ignore_during_wait();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
